// File: rtl/ni_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ni_pkg
//  Description : Shared types and constants for the network interface.
//                Provides the packet length, the flit type, the NI transmit
//                arbiter state encoding and a one-hot to index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ni_pkg;

    // Flits per packet: head + bodies + tail.
    localparam int TOTAL_FLITS = 4;

    // Native NoC flit width of the network interface.
    localparam int NI_FLIT_W   = 16;

    // Largest requester count supported by the arbiter and its helpers.
    localparam int MAX_REQ     = 8;

    typedef logic [NI_FLIT_W-1:0] flit_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Index of the set bit of a one-hot vector (zero for an all-zero vector).
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] i_vec);
        logic [2:0] w_idx;
        w_idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (i_vec[k]) begin
                w_idx = 3'(k);
            end
        end
        return w_idx;
    endfunction

endpackage : ni_pkg
`default_nettype wire

// File: rtl/ni_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Scans the request
//                vector starting one position after the previous winner,
//                wrapping modulo N, and returns the first requester found.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_req        in  N      request vector
//    i_last_grant in  IW     index of the previous winner (lowest priority)
//    o_grant      out N      one-hot winner (zero when nothing requests)
//    o_any_req    out 1      at least one request present
// ============================================================================
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_grant,
    output logic [N-1:0]  o_grant,
    output logic          o_any_req
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // k runs 1..N so the previous winner is visited last.
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(i_last_grant) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule : rr_pick
`default_nettype wire

// File: rtl/ni_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ni_tx_arbiter
//  Description : Packet-level round-robin arbiter sharing the NI output link
//                between NUM_REQ flit sources. A source that wins on its head
//                flit owns the link until its tail flit (PKT_FLITS flits) has
//                transferred. A watchdog aborts a lock whose owner stops
//                presenting flits for TIMEOUT consecutive cycles.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          in  1               system clock
//    reset        in  1               asynchronous active-high reset
//    req_valid    in  NUM_REQ         per-source flit valid
//    req_flit     in  NUM_REQ*FLIT_W  per-source flit, source i at [i*FLIT_W +: FLIT_W]
//    req_ready    out NUM_REQ         per-source flit accepted this cycle
//    o_flit       out FLIT_W          flit to NoC
//    valid_out    out 1               o_flit valid
//    ready_in     in  1               NoC can accept a flit
//    grant        out NUM_REQ         one-hot current owner, zero in IDLE
//    busy         out 1               link locked by a source
//    err_timeout  out 1               one-cycle pulse on watchdog abort
// ============================================================================
module ni_tx_arbiter
    import ni_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int FLIT_W    = 16,
    parameter int PKT_FLITS = TOTAL_FLITS,
    parameter int TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [FLIT_W-1:0]         o_flit,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(PKT_FLITS);
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e         r_state,     w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,     w_grant_nxt;
    logic [GW-1:0]      r_gidx,      w_gidx_nxt;
    logic [GW-1:0]      r_last,      w_last_nxt;
    logic [CW-1:0]      r_flit_cnt,  w_flit_cnt_nxt;
    logic [SW-1:0]      r_stall_cnt, w_stall_cnt_nxt;

    logic [NUM_REQ-1:0] w_pick;
    logic [GW-1:0]      w_pick_idx;
    logic               w_any;
    logic               w_busy;
    logic               w_gvalid;
    logic               w_xfer;
    logic               w_tail;
    logic               w_abort;

    // ------------------------------------------------------------------
    // Round-robin selection among the current requesters
    // ------------------------------------------------------------------
    rr_pick #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_rr_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last),
        .o_grant      (w_pick),
        .o_any_req    (w_any)
    );

    assign w_pick_idx = GW'(onehot_to_idx(MAX_REQ'(w_pick)));

    // ------------------------------------------------------------------
    // Datapath: the output link mirrors the owner's flit source while
    // locked and is silent otherwise.
    // ------------------------------------------------------------------
    assign w_busy   = (r_state == ARB_LOCK);
    assign w_gvalid = req_valid[r_gidx];
    assign w_xfer   = w_busy && w_gvalid && ready_in;
    assign w_tail   = w_xfer && (r_flit_cnt == CW'(PKT_FLITS - 1));

    // Abort fires during the TIMEOUT-th consecutive empty cycle; backpressure
    // with a valid flit present never contributes.
    assign w_abort  = (TIMEOUT > 0) && w_busy && !w_gvalid &&
                      (r_stall_cnt == SW'(TIMEOUT - 1));

    assign o_flit      = w_busy ? req_flit[int'(r_gidx)*FLIT_W +: FLIT_W] : '0;
    assign valid_out   = w_busy && w_gvalid;
    assign req_ready   = w_busy ? (r_grant & {NUM_REQ{ready_in}}) : '0;
    assign grant       = r_grant;
    assign busy        = w_busy;
    assign err_timeout = w_abort;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_gidx_nxt      = r_gidx;
        w_last_nxt      = r_last;
        w_flit_cnt_nxt  = r_flit_cnt;
        w_stall_cnt_nxt = r_stall_cnt;

        case (r_state)
            ARB_IDLE: begin
                w_flit_cnt_nxt  = '0;
                w_stall_cnt_nxt = '0;
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_gidx_nxt  = w_pick_idx;
                    w_state_nxt = ARB_LOCK;
                end
            end

            ARB_LOCK: begin
                if (w_tail) begin
                    w_flit_cnt_nxt = '0;
                    w_last_nxt     = r_gidx;
                    w_grant_nxt    = '0;
                    w_state_nxt    = ARB_IDLE;
                end else if (w_xfer) begin
                    w_flit_cnt_nxt = r_flit_cnt + CW'(1);
                end

                if (w_gvalid) begin
                    w_stall_cnt_nxt = '0;
                end else if (w_abort) begin
                    w_stall_cnt_nxt = '0;
                    w_flit_cnt_nxt  = '0;
                    w_last_nxt      = r_gidx;
                    w_grant_nxt     = '0;
                    w_state_nxt     = ARB_IDLE;
                end else if (TIMEOUT > 0) begin
                    w_stall_cnt_nxt = r_stall_cnt + SW'(1);
                end
            end

            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. last_grant resets to the top index so source 0
    // has first priority; an interrupted packet is simply dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_last      <= GW'(NUM_REQ - 1);
            r_flit_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_gidx      <= w_gidx_nxt;
            r_last      <= w_last_nxt;
            r_flit_cnt  <= w_flit_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

endmodule : ni_tx_arbiter
`default_nettype wire

// File: tb/tb_ni_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ni_tx_arbiter
//  Description : Self-checking bench for ni_tx_arbiter (2 sources, 4-flit
//                packets, watchdog of 8). A packet-level reference model is
//                compared with the DUT every cycle; directed scenarios add
//                hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_tx_arbiter;

    localparam int NR = 2;
    localparam int FW = 16;
    localparam int PF = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*FW-1:0] req_flit;
    logic [NR-1:0]    req_ready;
    logic [FW-1:0]    o_flit;
    logic             valid_out;
    logic             ready_in;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             err_timeout;

    int checks   = 0;
    int failures = 0;

    logic [15:0] got[$];
    int          src_pos[NR];
    bit          src_on[NR];

    // Reference model: owner (-1 when the link is free), flits sent in the
    // current packet, consecutive empty cycles, previous owner.
    int m_owner  = -1;
    int m_sent   = 0;
    int m_stalls = 0;
    int m_last   = NR - 1;

    ni_tx_arbiter #(
        .NUM_REQ   (NR),
        .FLIT_W    (FW),
        .PKT_FLITS (PF),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_flit    (req_flit),
        .req_ready   (req_ready),
        .o_flit      (o_flit),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Source s, stream position p: packet k = p/4, flit j = p%4 -> base + k*0x10 + j + 1
    function automatic logic [15:0] flit_of(input int s, input int p);
        int v;
        v = (s == 0) ? 'hA000 : 'hB000;
        v = v + (p / 4) * 16 + (p % 4) + 1;
        return v[15:0];
    endfunction

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = src_on[i];
            req_flit[i*FW +: FW] = flit_of(i, src_pos[i]);
        end
    endtask

    // One clock: sources advance on flits accepted at this edge.
    task automatic step();
        logic [NR-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) src_pos[i]++;
        end
        apply();
        #1;
    endtask

    task automatic run_until(input int n, input int lim, output int cyc);
        cyc = 0;
        while (got.size() < n && cyc < lim) begin
            step();
            cyc++;
        end
        if (got.size() < n) chk("wait_bound", got.size(), n);
    endtask

    task automatic chk_seq(input string name, input logic [15:0] exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size(); k++) begin
            chk(name, (k < got.size()) ? {16'h0, got[k]} : 32'hxxxx_xxxx, {16'h0, exp[k]});
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < NR; i++) begin
            src_on[i]  = 1'b0;
            src_pos[i] = 0;
        end
        apply();
        step();
        step();
        reset = 1'b0;
        #1;
        got.delete();
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare against the reference model (falling edge)
    // ------------------------------------------------------------------
    initial begin
        logic [NR-1:0] e_grant, e_rdy;
        logic [FW-1:0] e_flit;
        logic          e_busy, e_valid, e_err;
        int            o, c;
        forever begin
            @(negedge clk);
            e_grant = '0; e_rdy = '0; e_flit = '0;
            e_busy = 1'b0; e_valid = 1'b0; e_err = 1'b0;
            if (!reset && m_owner >= 0) begin
                o = m_owner;
                e_grant[o] = 1'b1;
                e_busy     = 1'b1;
                e_valid    = req_valid[o];
                e_flit     = req_flit[o*FW +: FW];
                e_rdy[o]   = ready_in;
                e_err      = !req_valid[o] && (m_stalls + 1 == TO);
            end
            chk("cyc_grant", grant, e_grant);
            chk("cyc_busy", busy, e_busy);
            chk("cyc_valid_out", valid_out, e_valid);
            chk("cyc_o_flit", o_flit, e_flit);
            chk("cyc_req_ready", req_ready, e_rdy);
            chk("cyc_err_timeout", err_timeout, e_err);

            if (!reset && valid_out && ready_in) got.push_back(o_flit);

            // Advance the model to the state after the coming edge.
            if (reset) begin
                m_owner = -1; m_sent = 0; m_stalls = 0; m_last = NR - 1;
            end else if (m_owner < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    c = (m_last + k) % NR;
                    if (m_owner < 0 && req_valid[c]) m_owner = c;
                end
                m_sent = 0; m_stalls = 0;
            end else begin
                o = m_owner;
                if (req_valid[o]) begin
                    m_stalls = 0;
                    if (ready_in) begin
                        m_sent++;
                        if (m_sent == PF) begin
                            m_last = o; m_owner = -1; m_sent = 0;
                        end
                    end
                end else begin
                    m_stalls++;
                    if (m_stalls == TO) begin
                        m_last = o; m_owner = -1; m_sent = 0; m_stalls = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int cyc;
        logic [15:0] e[$];

        reset     = 1'b1;
        ready_in  = 1'b1;
        req_valid = '0;
        req_flit  = '0;

        // Reset state
        do_reset();
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);

        // Single source, one packet
        src_on[0] = 1'b1; apply(); #1;
        chk("t1_idle_bubble", grant, 2'b00);
        step();
        chk("t1_grant", grant, 2'b01);
        chk("t1_head", o_flit, 16'hA001);
        run_until(4, 12, cyc);
        chk("t1_cycles", cyc, 4);
        chk("t1_grant_after", grant, 2'b00);
        chk("t1_busy_after", busy, 1'b0);
        e = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        chk_seq("t1_seq", e);
        src_on[0] = 1'b0; apply();

        // Two continuous sources alternate packets with one bubble each
        do_reset();
        src_on[0] = 1'b1; src_on[1] = 1'b1; apply(); #1;
        run_until(16, 60, cyc);
        chk("t2_cycles", cyc, 20);
        e = '{16'hA001, 16'hA002, 16'hA003, 16'hA004,
              16'hB001, 16'hB002, 16'hB003, 16'hB004,
              16'hA011, 16'hA012, 16'hA013, 16'hA014,
              16'hB011, 16'hB012, 16'hB013, 16'hB014};
        chk_seq("t2_seq", e);

        // Backpressure on source 1 after its first body flit
        do_reset();
        src_on[1] = 1'b1; apply(); #1;
        step();
        chk("t3_grant", grant, 2'b10);
        step();
        ready_in = 1'b0; apply(); #1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_hold_flit", o_flit, 16'hB002);
            chk("t3_hold_valid", valid_out, 1'b1);
            chk("t3_hold_ready", req_ready, 2'b00);
            step();
        end
        ready_in = 1'b1; apply(); #1;
        run_until(4, 12, cyc);
        e = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
        chk_seq("t3_seq", e);
        src_on[1] = 1'b0; apply();

        // Owner gap: lock is kept, source 1 never interleaves
        do_reset();
        src_on[0] = 1'b1; src_on[1] = 1'b1; apply(); #1;
        step(); step(); step();
        src_on[0] = 1'b0; apply(); #1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_gap_valid", valid_out, 1'b0);
            chk("t4_gap_rdy1", req_ready[1], 1'b0);
            chk("t4_gap_grant", grant, 2'b01);
            step();
        end
        src_on[0] = 1'b1; apply(); #1;
        run_until(8, 30, cyc);
        e = '{16'hA001, 16'hA002, 16'hA003, 16'hA004,
              16'hB001, 16'hB002, 16'hB003, 16'hB004};
        chk_seq("t4_seq", e);

        // Watchdog: source 0 stops after its head flit
        do_reset();
        src_on[0] = 1'b1; src_on[1] = 1'b1; apply(); #1;
        step(); step();
        src_on[0] = 1'b0; apply(); #1;
        for (int k = 1; k <= TO; k++) begin
            chk("t5_err_pulse", err_timeout, (k == TO) ? 1'b1 : 1'b0);
            step();
        end
        chk("t5_idle_grant", grant, 2'b00);
        chk("t5_idle_err", err_timeout, 1'b0);
        step();
        chk("t5_next_grant", grant, 2'b10);
        e = '{16'hA001};
        chk_seq("t5_seq", e);

        // Asynchronous reset mid-packet
        do_reset();
        src_on[0] = 1'b1; apply(); #1;
        step(); step(); step();
        reset = 1'b1; #1;
        chk("t6_async_valid", valid_out, 1'b0);
        chk("t6_async_grant", grant, 2'b00);
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_flit", o_flit, 16'h0000);
        chk("t6_async_rdy", req_ready, 2'b00);
        src_pos[0] = 0; apply();
        step();
        reset = 1'b0; #1;
        got.delete();
        run_until(4, 12, cyc);
        chk("t6_cycles", cyc, 5);
        chk("t6_grant_after", grant, 2'b00);
        e = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        chk_seq("t6_seq", e);
        src_on[0] = 1'b0; apply();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_ni_tx_arbiter
`default_nettype wire
